// File: rtl/conv_shell1_row_sequencer.sv
// conv_shell1_row_sequencer: walks one conv tile (row group -> kernel row -> feature) emitting address beats
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   start, abort          tile start pulse (IDLE only), synchronous cancel
//   cfg_k, cfg_nif_in_2pow, cfg_rb_start, cfg_rb_cnt, cfg_poy   tile config, latched on start
//   ky, if_start, row_base_in_3s   current beat address fields
//   valid_adr, adr_ready, last     beat handshake, last marks the final beat of the tile
//   busy, done                     high in RUN, 1-cycle completion pulse
module conv_shell1_row_sequencer #(
   parameter int KY_W         = 16,
   parameter int RB_W         = 16,
   parameter int NIF_2POW_MAX = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic [KY_W-1:0] cfg_k,
   input  logic [3:0]      cfg_nif_in_2pow,
   input  logic [RB_W-1:0] cfg_rb_start,
   input  logic [RB_W-1:0] cfg_rb_cnt,
   input  logic [15:0]     cfg_poy,
   output logic [KY_W-1:0] ky,
   output logic [15:0]     if_start,
   output logic [RB_W-1:0] row_base_in_3s,
   output logic            valid_adr,
   input  logic            adr_ready,
   output logic            last,
   output logic            busy,
   output logic            done
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t          state;
   logic [16:0]     if_cnt, if_max, if_max_cfg, if_nx;
   logic [KY_W-1:0] k_last, ky_nx;
   logic [RB_W-1:0] rb_last, rb_nx;
   logic [3:0]      nif_c;
   logic            empty, acc, if_wrap, ky_wrap, last_nx, last_ld;
   assign if_start = if_cnt[15:0];
   always_comb begin
      nif_c      = cfg_nif_in_2pow > 4'(NIF_2POW_MAX) ? 4'(NIF_2POW_MAX) : cfg_nif_in_2pow;
      if_max_cfg = 17'd1 << nif_c;
      empty      = cfg_k == '0 || cfg_rb_cnt == '0 || cfg_poy == '0;
      acc        = valid_adr & adr_ready;
      if_wrap    = if_cnt == if_max;
      ky_wrap    = ky == k_last;
      if_nx      = if_wrap ? 17'd1 : if_cnt + 17'd1;
      ky_nx      = if_wrap ? (ky_wrap ? '0 : ky + KY_W'(1)) : ky;
      rb_nx      = (if_wrap && ky_wrap) ? row_base_in_3s + RB_W'(1) : row_base_in_3s;
      // last is registered, so it is predicted from the address the next beat will carry
      last_nx    = if_nx == if_max && ky_nx == k_last && rb_nx == rb_last;
      last_ld    = if_max_cfg == 17'd1 && cfg_k == KY_W'(1) && cfg_rb_cnt == RB_W'(1);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         ky             <= '0;
         if_cnt         <= '0;
         row_base_in_3s <= '0;
         valid_adr      <= 1'b0;
         last           <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         k_last         <= '0;
         rb_last        <= '0;
         if_max         <= '0;
      end else if (abort) begin
         state     <= IDLE;
         valid_adr <= 1'b0;
         last      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               k_last  <= cfg_k - KY_W'(1);
               rb_last <= cfg_rb_start + cfg_rb_cnt - RB_W'(1);
               if_max  <= if_max_cfg;
               if (empty) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state          <= RUN;
                  busy           <= 1'b1;
                  valid_adr      <= 1'b1;
                  ky             <= '0;
                  if_cnt         <= 17'd1;
                  row_base_in_3s <= cfg_rb_start;
                  last           <= last_ld;
               end
            end
            RUN: if (acc) begin
               if (last) begin
                  state     <= DONE;
                  valid_adr <= 1'b0;
                  last      <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
               end else begin
                  if_cnt         <= if_nx;
                  ky             <= ky_nx;
                  row_base_in_3s <= rb_nx;
                  last           <= last_nx;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
